// File: rtl/filter_video_pkg.sv
// Shared definitions for the video timing / test-pattern generator.
package filter_video_pkg;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FCNT  = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A checkerboard cell is lit when exactly one coordinate sits in an odd 8-pixel tile.
    function automatic logic check_cell(input logic x_bit, input logic ln_bit);
        return x_bit ^ ln_bit;
    endfunction

endpackage

// File: rtl/filter_video_pattern.sv
// Combinational pattern datapath: maps pattern, coordinates and frame count to Y/U/V.
module filter_video_pattern
    import filter_video_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [1:0]            pattern_i,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] ln_i,
    input  logic                  de_i,
    input  logic [DATA_WIDTH-1:0] frame_cnt_i,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic [DATA_WIDTH-1:0] u_o,
    output logic [DATA_WIDTH-1:0] v_o
);

    localparam logic [DATA_WIDTH-1:0] CHROMA_MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES   = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ALL_ZEROS  = {DATA_WIDTH{1'b0}};

    // Pixel value selection; everything is blanked outside the active window.
    always_comb begin
        y_o = ALL_ZEROS;
        u_o = ALL_ZEROS;
        v_o = ALL_ZEROS;
        if (de_i) begin
            u_o = CHROMA_MID;
            v_o = CHROMA_MID;
            case (pattern_e'(pattern_i))
                PAT_HRAMP: y_o = x_i;
                PAT_VRAMP: y_o = ln_i;
                PAT_CHECK: y_o = check_cell(x_i[3], ln_i[3]) ? ALL_ONES : ALL_ZEROS;
                PAT_FCNT:  y_o = frame_cnt_i;
                default:   y_o = ALL_ZEROS;
            endcase
        end else begin
            y_o = ALL_ZEROS;
            u_o = ALL_ZEROS;
            v_o = ALL_ZEROS;
        end
    end

endmodule

// File: rtl/filter_video_gen.sv
// Video timing and test-pattern source: raster counters, run/idle FSM and registered
// vs/hs/de/Y/U/V outputs, one cycle behind the counter state they describe.
module filter_video_gen
    import filter_video_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter int H_CNT_WIDTH = 12,
    parameter int V_CNT_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_enable,
    input  logic [1:0]            i_pattern,
    output logic                  o_vs,
    output logic                  o_hs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic [DATA_WIDTH-1:0] o_u,
    output logic [DATA_WIDTH-1:0] o_v,
    output logic                  o_busy,
    output logic [15:0]           o_frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [H_CNT_WIDTH-1:0] H_LAST   = H_CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [V_CNT_WIDTH-1:0] V_LAST   = V_CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [H_CNT_WIDTH-1:0] H_BEGIN  = H_CNT_WIDTH'(H_START);
    localparam logic [H_CNT_WIDTH-1:0] H_END    = H_CNT_WIDTH'(H_START + H_ACTIVE);
    localparam logic [V_CNT_WIDTH-1:0] V_BEGIN  = V_CNT_WIDTH'(V_START);
    localparam logic [V_CNT_WIDTH-1:0] V_END    = V_CNT_WIDTH'(V_START + V_ACTIVE);
    localparam logic [H_CNT_WIDTH-1:0] H_SYNC_W = H_CNT_WIDTH'(H_SYNC);
    localparam logic [V_CNT_WIDTH-1:0] V_SYNC_W = V_CNT_WIDTH'(V_SYNC);

    state_e                 state_q;
    logic [H_CNT_WIDTH-1:0] h_cnt_q;
    logic [V_CNT_WIDTH-1:0] v_cnt_q;
    logic [1:0]             pat_q;
    logic [15:0]            frame_cnt_q;

    logic                  run_s;
    logic                  hs_d;
    logic                  vs_d;
    logic                  de_d;
    logic [DATA_WIDTH-1:0] x_s;
    logic [DATA_WIDTH-1:0] ln_s;
    logic [DATA_WIDTH-1:0] y_d;
    logic [DATA_WIDTH-1:0] u_d;
    logic [DATA_WIDTH-1:0] v_d;

    assign run_s = (state_q == ST_RUN);
    assign hs_d  = run_s && (h_cnt_q < H_SYNC_W);
    assign vs_d  = run_s && (v_cnt_q < V_SYNC_W);
    assign de_d  = run_s && (h_cnt_q >= H_BEGIN) && (h_cnt_q < H_END)
                         && (v_cnt_q >= V_BEGIN) && (v_cnt_q < V_END);
    assign x_s   = DATA_WIDTH'(h_cnt_q - H_BEGIN);
    assign ln_s  = DATA_WIDTH'(v_cnt_q - V_BEGIN);

    filter_video_pattern #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .pattern_i   (pat_q),
        .x_i         (x_s),
        .ln_i        (ln_s),
        .de_i        (de_d),
        .frame_cnt_i (DATA_WIDTH'(frame_cnt_q)),
        .y_o         (y_d),
        .u_o         (u_d),
        .v_o         (v_d)
    );

    // Run/idle FSM with raster counters; a frame only starts or stops at its boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pat_q       <= 2'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (i_enable) begin
                        state_q <= ST_RUN;
                        pat_q   <= i_pattern;
                    end
                end
                ST_RUN: begin
                    if (h_cnt_q == H_LAST) begin
                        h_cnt_q <= '0;
                        if (v_cnt_q == V_LAST) begin
                            v_cnt_q     <= '0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            if (i_enable) begin
                                pat_q <= i_pattern;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            v_cnt_q <= v_cnt_q + V_CNT_WIDTH'(1);
                        end
                    end else begin
                        h_cnt_q <= h_cnt_q + H_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                end
            endcase
        end
    end

    // Output stage: timing and pixel data reflect the previous cycle's counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vs   <= 1'b0;
            o_hs   <= 1'b0;
            o_de   <= 1'b0;
            o_y    <= '0;
            o_u    <= '0;
            o_v    <= '0;
            o_busy <= 1'b0;
        end else begin
            o_vs   <= vs_d;
            o_hs   <= hs_d;
            o_de   <= de_d;
            o_y    <= y_d;
            o_u    <= u_d;
            o_v    <= v_d;
            o_busy <= run_s;
        end
    end

    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_filter_video_gen.sv
// Directed bench for filter_video_gen on a 22x7 raster (154-cycle frames).
module tb_filter_video_gen;

    localparam int HT    = 22;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_pattern = 2'd0;
    logic       o_vs, o_hs, o_de, o_busy;
    logic [7:0] o_y, o_u, o_v;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    filter_video_gen #(
        .DATA_WIDTH (8),
        .H_ACTIVE   (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE   (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_CNT_WIDTH(12), .V_CNT_WIDTH(11)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_enable    (i_enable),
        .i_pattern   (i_pattern),
        .o_vs        (o_vs),
        .o_hs        (o_hs),
        .o_de        (o_de),
        .o_y         (o_y),
        .o_u         (o_u),
        .o_v         (o_v),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_y(input int k, input logic [1:0] pat, input int fnum);
        int x;
        int ln;
        x  = (k % HT) - 4;
        ln = (k / HT) - 2;
        case (pat)
            2'd0:    return 8'(x);
            2'd1:    return 8'(ln);
            2'd2:    return ((((x >> 3) ^ (ln >> 3)) & 1) != 0) ? 8'd255 : 8'd0;
            default: return 8'(fnum);
        endcase
    endfunction

    function automatic logic [31:0] out_bits();
        return {4'd0, o_vs, o_hs, o_de, o_busy, o_y, o_u, o_v};
    endfunction

    // Samples one full frame starting at its (0,0) output, optionally changing inputs mid-frame.
    task automatic capture(input string tag, input logic [1:0] pat, input int fnum,
                           input int chg_k, input logic [1:0] chg_pat, input int drop_k,
                           input logic [7:0] y48, input logic [7:0] y63);
        int de_n = 0, hs_n = 0, vs_n = 0, first_de = -1;
        int bad_t = 0, bad_y = 0, bad_blank = 0, busy_lo = 0, fc1 = 0;
        logic [7:0] ya = 8'd0, yb = 8'd0;
        for (int k = 0; k < FRAME; k++) begin
            int h, v;
            logic de_e;
            @(negedge clk);
            h = k % HT;
            v = k / HT;
            de_e = (h >= 4) && (h < 20) && (v >= 2) && (v < 6);
            if (o_de) begin
                de_n++;
                if (first_de < 0) first_de = k;
            end
            hs_n += int'(o_hs);
            vs_n += int'(o_vs);
            if (o_de !== de_e || o_hs !== (h < 2) || o_vs !== (v < 1)) bad_t++;
            if (de_e) begin
                if (o_y !== exp_y(k, pat, fnum) || o_u !== 8'd128 || o_v !== 8'd128) bad_y++;
            end else if ({o_y, o_u, o_v} !== 24'd0) begin
                bad_blank++;
            end
            if (o_busy !== 1'b1) busy_lo++;
            if (k == 1)  fc1 = int'(o_frame_cnt);
            if (k == 48) ya = o_y;
            if (k == 63) yb = o_y;
            if (k == chg_k)  i_pattern = chg_pat;
            if (k == drop_k) i_enable = 1'b0;
        end
        check_eq({tag, "_de_cnt"},   de_n, 64);
        check_eq({tag, "_hs_cnt"},   hs_n, 14);
        check_eq({tag, "_vs_cnt"},   vs_n, 22);
        check_eq({tag, "_first_de"}, first_de, 48);
        check_eq({tag, "_timing"},   bad_t, 0);
        check_eq({tag, "_pixels"},   bad_y, 0);
        check_eq({tag, "_blank"},    bad_blank, 0);
        check_eq({tag, "_busy"},     busy_lo, 0);
        check_eq({tag, "_fcnt"},     fc1, fnum);
        check_eq({tag, "_y_x0"},     ya, y48);
        check_eq({tag, "_y_x15"},    yb, y63);
    endtask

    initial begin
        logic [31:0] any;

        repeat (3) @(negedge clk);
        check_eq("rst_outputs", out_bits(), 32'd0);
        check_eq("rst_fcnt", o_frame_cnt, 32'd0);
        rstn = 1'b1;
        any = 32'd0;
        repeat (50) begin
            @(negedge clk);
            any |= out_bits();
        end
        check_eq("idle_quiet", any, 32'd0);
        check_eq("idle_fcnt", o_frame_cnt, 32'd0);

        i_pattern = 2'd0;
        i_enable  = 1'b1;
        @(negedge clk);
        check_eq("start_lat_busy", o_busy, 32'd0);
        check_eq("start_lat_vs", o_vs, 32'd0);
        capture("p0", 2'd0, 0, 70, 2'd1, -1, 8'd0, 8'd15);
        capture("p1", 2'd1, 1, 70, 2'd2, -1, 8'd0, 8'd0);
        capture("p2", 2'd2, 2, -1, 2'd0, -1, 8'd0, 8'd255);

        i_enable = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        i_pattern = 2'd0;
        @(negedge clk);
        i_enable = 1'b1;
        @(negedge clk);
        capture("drop", 2'd0, 0, -1, 2'd0, 60, 8'd0, 8'd15);
        @(negedge clk);
        check_eq("drop_busy", o_busy, 32'd0);
        check_eq("drop_outputs", out_bits(), 32'd0);
        check_eq("drop_fcnt", o_frame_cnt, 32'd1);
        any = 32'd0;
        repeat (20) begin
            @(negedge clk);
            any |= out_bits();
        end
        check_eq("drop_stays_idle", any, 32'd0);
        check_eq("drop_fcnt_hold", o_frame_cnt, 32'd1);

        rstn = 1'b0;
        @(negedge clk);
        check_eq("p3_pre_fcnt", o_frame_cnt, 32'd0);
        rstn = 1'b1;
        i_pattern = 2'd3;
        i_enable  = 1'b1;
        @(negedge clk);
        capture("p3_f0", 2'd3, 0, -1, 2'd0, -1, 8'd0, 8'd0);
        capture("p3_f1", 2'd3, 1, -1, 2'd0, -1, 8'd1, 8'd1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 48) check_eq("p3_f2_y", o_y, 32'd2);
        end
        rstn = 1'b0;
        #1;
        check_eq("midrst_outputs", out_bits(), 32'd0);
        check_eq("midrst_fcnt", o_frame_cnt, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("restart_lat_busy", o_busy, 32'd0);
        capture("restart", 2'd3, 0, -1, 2'd0, -1, 8'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_video_gen.md
# filter_video_gen

Video timing and test-pattern source for the image filter pipeline. Generates `vs`/`hs`/`de` raster timing with Y/U/V pixel data in the same format the filter top consumes. It drives the filter input in standalone bring-up and in regression benches. Frames start only on a frame boundary and always complete once started.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel component width
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (cycles)
- H_SYNC, 44, hsync width (cycles)
- H_BP, 148, horizontal back porch (cycles)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- H_CNT_WIDTH, 12, horizontal counter width; must hold H_TOTAL-1
- V_CNT_WIDTH, 11, vertical counter width; must hold V_TOTAL-1

Ports:
- clk  in  1  single clock
- rstn  in  1  reset; asynchronous, active-low
- i_enable  in  1  run request, level
- i_pattern  in  2  pattern select: 0 h-ramp, 1 v-ramp, 2 checkerboard, 3 flat frame count
- o_vs  out  1  vsync, active-high
- o_hs  out  1  hsync, active-high
- o_de  out  1  data enable
- o_y  out  DATA_WIDTH  luma
- o_u  out  DATA_WIDTH  chroma U
- o_v  out  DATA_WIDTH  chroma V
- o_busy  out  1  high while a frame is in progress
- o_frame_cnt  out  16  completed-frame count, wraps at 0xFFFF→0

## Operation
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Line order: sync, back porch, active, front porch. The same order applies vertically.
- h_cnt runs 0..H_TOTAL-1 and wraps, incrementing v_cnt. v_cnt runs 0..V_TOTAL-1.
- hs = h_cnt < H_SYNC.
- vs = v_cnt < V_SYNC. vs is asserted for whole lines, starting at h_cnt 0.
- de = (H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACTIVE) AND (V_SYNC+V_BP ≤ v_cnt < V_SYNC+V_BP+V_ACTIVE).
- Coordinates: x = h_cnt-(H_SYNC+H_BP) and ln = v_cnt-(V_SYNC+V_BP), each truncated to its DATA_WIDTH LSBs for data.
- FSM states:
  - IDLE: counters held at 0, all outputs 0. If i_enable=1, go to RUN and latch i_pattern into pat_q.
  - RUN: counters advance every cycle. At the last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1), frame_cnt increments. Then:
    - if i_enable=1, stay in RUN, relatch pat_q, and restart at (0,0) with no gap;
    - otherwise go to IDLE.
- i_enable low mid-frame: the frame completes, then the block goes idle. i_enable and i_pattern changes mid-frame have no effect until the frame boundary.
- Data when de=1:
  - pattern 0: y = x
  - pattern 1: y = ln
  - pattern 2: y = all-ones if x[3]^ln[3], else 0
  - pattern 3: y = frame_cnt[DATA_WIDTH-1:0]
  - u = v = 1<<(DATA_WIDTH-1) for all patterns.
- Data when de=0: y = u = v = 0.

## Timing
- All outputs are registered, one cycle after the counter state they reflect.
- Start latency: i_enable sampled high in IDLE at cycle N → counters at (0,0) in cycle N+1 → o_vs=o_hs=1 at N+2.
- o_busy = (state==RUN), registered with the same one-cycle alignment as o_vs/o_hs/o_de.
- Back-to-back frames have no idle cycles. Frame period is exactly H_TOTAL·V_TOTAL cycles.
- o_frame_cnt updates in the cycle after the last pixel position of a frame.
- Reset:
  - rstn low clears all outputs, counters, pat_q and frame_cnt to 0 immediately, and puts the FSM in IDLE.
  - Reset mid-frame truncates the frame; it does not resume.
  - After rstn is released, a new start requires i_enable to be sampled high.

## Structure
- Shared package filter_video_pkg:
  - pattern codes PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_FCNT=3;
  - FSM state encoding ST_IDLE, ST_RUN.
- Sub-module filter_video_pattern: combinational pattern datapath (pattern, x, ln, de, frame_cnt → y/u/v). The top registers its outputs.
- The top contains the FSM, h/v counters, frame counter and output registers.

## Test plan
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=22); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); frame = 154 cycles.
- Reset, then i_enable=0 for 50 cycles → all outputs 0, o_frame_cnt=0.
- Pattern 0, i_enable=1 held:
  - first o_de appears on line 2, h offset 4;
  - 16 de cycles per line, y=0..15, u=v=128;
  - 4 de lines per frame;
  - hs is 2 cycles per 22;
  - vs is 22 cycles per 154.
- Pattern 2 → on every line, y=0 for x 0..7 and y=255 for x 8..15 (ln<8).
- i_pattern changed 0→1 mid-frame → current frame stays a ramp in x; the next frame is y=ln (0..3 per line).
- i_enable dropped at cycle 60 of a frame → frame runs to 154 cycles, o_frame_cnt=1, then o_busy=0 and outputs go to 0.
- Pattern 3 over 3 frames → flat y=0, 1, 2. rstn pulsed low mid-frame 2 → outputs 0 at once, o_frame_cnt=0, and the block restarts at (0,0) after release.
